// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the 2-way set-associative data cache.
package dcache_pkg;

  // Cache controller states.
  typedef enum logic [2:0] {
    StIdle,
    StMiss,
    StWb,
    StRefill,
    StFill
  } state_e;

  localparam int unsigned WordW = 32;

  // Byte-offset width of one line.
  function automatic int unsigned calc_off_w(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  // Set-index width.
  function automatic int unsigned calc_idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Tag width: whatever address bits are left above index and offset.
  function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                             input int unsigned line_w,
                                             input int unsigned sets);
    return addr_w - calc_idx_w(sets) - calc_off_w(line_w);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/dirty/tag/line arrays with a combinational read port and
// a synchronous, word-masked write port.
module dcache_way import dcache_pkg::*; #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned SETS   = 32,
  parameter int unsigned TAG_W  = 22,
  localparam int unsigned IDX_W = calc_idx_w(SETS),
  localparam int unsigned WORDS = LINE_W / WordW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WORDS-1:0]  wr_mask_i,
  input  logic [LINE_W-1:0] wr_line_i,
  input  logic              wr_dirty_i,
  input  logic [TAG_W-1:0]  wr_tag_i
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  // Status bits: cleared by reset; every write (fill or store hit) leaves the entry valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Tag and data storage: plain memory, no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      for (int w = 0; w < WORDS; w++) begin
        if (wr_mask_i[w]) begin
          line_q[wr_idx_i][w*WordW +: WordW] <= wr_line_i[w*WordW +: WordW];
        end
      end
    end
  end

  assign valid_o = valid_q[rd_idx_i];
  assign dirty_o = dirty_q[rd_idx_i];
  assign tag_o   = tag_q[rd_idx_i];
  assign line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back, write-allocate L1 data cache with per-set LRU,
// victim writeback and saturating hit/miss counters. Stalls the CPU on a miss.
module dcache_2way_top import dcache_pkg::*; #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned SETS   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned OFF_W = calc_off_w(LINE_W);
  localparam int unsigned IDX_W = calc_idx_w(SETS);
  localparam int unsigned TAG_W = calc_tag_w(ADDR_W, LINE_W, SETS);
  localparam int unsigned WORDS = LINE_W / WordW;
  localparam int unsigned SEL_W = OFF_W - 2;

  // Request decode
  logic             req, is_wr;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [SEL_W-1:0] word_sel;
  logic             unused_addr_bits;

  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign is_wr            = p1_MemWrite_i; // read+write together behaves as a write
  assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
  assign word_sel         = p1_addr_i[2 +: SEL_W];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  // State
  state_e            state_q, state_d;
  logic              victim_q, victim_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  // Way arrays
  logic [IDX_W-1:0]  rd_idx;
  logic [1:0]        way_valid, way_dirty, way_we;
  logic [TAG_W-1:0]  way_tag  [2];
  logic [LINE_W-1:0] way_line [2];
  logic [IDX_W-1:0]  wr_idx;
  logic [WORDS-1:0]  wr_mask;
  logic [LINE_W-1:0] wr_line;
  logic              wr_dirty;
  logic [TAG_W-1:0]  wr_tag;

  // Outside IDLE the set under service comes from the latched miss index.
  assign rd_idx = (state_q == StIdle) ? req_idx : miss_idx_q;

  dcache_way #(
    .LINE_W (LINE_W),
    .SETS   (SETS),
    .TAG_W  (TAG_W)
  ) u_way0 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (rd_idx),
    .valid_o    (way_valid[0]),
    .dirty_o    (way_dirty[0]),
    .tag_o      (way_tag[0]),
    .line_o     (way_line[0]),
    .we_i       (way_we[0]),
    .wr_idx_i   (wr_idx),
    .wr_mask_i  (wr_mask),
    .wr_line_i  (wr_line),
    .wr_dirty_i (wr_dirty),
    .wr_tag_i   (wr_tag)
  );

  dcache_way #(
    .LINE_W (LINE_W),
    .SETS   (SETS),
    .TAG_W  (TAG_W)
  ) u_way1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (rd_idx),
    .valid_o    (way_valid[1]),
    .dirty_o    (way_dirty[1]),
    .tag_o      (way_tag[1]),
    .line_o     (way_line[1]),
    .we_i       (way_we[1]),
    .wr_idx_i   (wr_idx),
    .wr_mask_i  (wr_mask),
    .wr_line_i  (wr_line),
    .wr_dirty_i (wr_dirty),
    .wr_tag_i   (wr_tag)
  );

  // Hit detection and read data
  logic [1:0]        hit_w;
  logic              hit, hit_way, victim_sel, serve, write_hit, fill;
  logic [LINE_W-1:0] hit_line;

  assign hit_w[0]  = way_valid[0] & (way_tag[0] == req_tag);
  assign hit_w[1]  = way_valid[1] & (way_tag[1] == req_tag);
  assign hit       = |hit_w;
  assign hit_way   = ~hit_w[0];
  assign hit_line  = hit_way ? way_line[1] : way_line[0];
  assign p1_stall_o = req & ~hit;

  // FILL also serves the request: the stall drops there, so a pending store lands then.
  assign serve     = (state_q == StIdle) | (state_q == StFill);
  assign write_hit = serve & is_wr & hit;
  assign fill      = (state_q == StRefill) & mem_ack_i;

  // First invalid way wins (way0 preferred), otherwise the LRU way.
  assign victim_sel = ~way_valid[0] ? 1'b0 :
                      ~way_valid[1] ? 1'b1 : lru_q[rd_idx];

  // Word select for load data; zero when nothing hits.
  always_comb begin
    p1_data_o = '0;
    if (hit) begin
      p1_data_o = hit_line[{word_sel, 5'b0} +: WordW];
    end
  end

  // Array write port: refill of the victim way, or a single-word store on a hit.
  always_comb begin
    way_we   = '0;
    wr_idx   = rd_idx;
    wr_mask  = '0;
    wr_line  = {WORDS{p1_data_i}};
    wr_dirty = 1'b1;
    wr_tag   = req_tag;
    if (fill) begin
      way_we[victim_q] = 1'b1;
      wr_idx           = miss_idx_q;
      wr_mask          = '1;
      wr_line          = mem_data_i;
      wr_dirty         = 1'b0;
      wr_tag           = miss_tag_q;
    end else if (write_hit) begin
      way_we[hit_way]   = 1'b1;
      wr_mask[word_sel] = 1'b1;
    end
  end

  // LRU update: the bit names the way that was not just touched.
  always_comb begin
    lru_d = lru_q;
    if (fill) begin
      lru_d[miss_idx_q] = ~victim_q;
    end else if (serve && req && hit) begin
      lru_d[rd_idx] = ~hit_way;
    end
  end

  // FSM next state and registered memory-request outputs.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    unique case (state_q)
      StIdle: begin
        if (req && !hit) begin
          state_d    = StMiss;
          victim_d   = victim_sel;
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
        end
      end
      StMiss: begin
        mem_enable_d = 1'b1;
        if (way_valid[victim_q] && way_dirty[victim_q]) begin
          state_d     = StWb;
          mem_write_d = 1'b1;
          mem_addr_d  = {way_tag[victim_q], miss_idx_q, {OFF_W{1'b0}}};
        end else begin
          state_d     = StRefill;
          mem_write_d = 1'b0;
          mem_addr_d  = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        end
      end
      StWb: begin
        if (mem_ack_i) begin
          state_d     = StRefill;
          mem_write_d = 1'b0;
          mem_addr_d  = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        end
      end
      StRefill: begin
        if (mem_ack_i) begin
          state_d      = StFill;
          mem_enable_d = 1'b0;
        end
      end
      StFill: begin
        state_d = StIdle;
      end
      default: begin
        state_d      = StIdle;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
      end
    endcase
  end

  // Saturating statistics counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StIdle && req) begin
      if (hit && hit_cnt_q != '1) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (!hit && miss_cnt_q != '1) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  // Controller registers; reset aborts any transfer immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      victim_q     <= 1'b0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      lru_q        <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      lru_q        <= lru_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = victim_q ? way_line[1] : way_line[0];
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_2way_top.sv
// Bench for dcache_2way_top: directed scenarios plus random traffic, each access
// checked against a set/way/LRU reference model and a latency-configurable memory.
module tb_dcache_2way_top;

  localparam int SETS = 32;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_addr_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  always #5 clk = ~clk;

  dcache_2way_top dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .p1_data_i     (p1_data_i),
    .p1_addr_i     (p1_addr_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: cache contents per way/set, LRU per set, model memory image.
  bit           m_valid [2][SETS];
  bit           m_dirty [2][SETS];
  logic [21:0]  m_tag   [2][SETS];
  logic [255:0] m_line  [2][SETS];
  bit           m_lru   [SETS];
  logic [31:0]  m_hits, m_misses;
  logic [255:0] model_mem [logic [31:0]];
  logic [255:0] resp_mem  [logic [31:0]];

  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'h1357_9BDF * (i + 1));
    return l;
  endfunction

  function automatic logic [255:0] mm_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return pattern(a);
  endfunction

  function automatic logic [255:0] rsp_read(input logic [31:0] a);
    if (resp_mem.exists(a)) return resp_mem[a];
    return pattern(a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
      m_lru[s] = 1'b0;
    end
    m_hits   = '0;
    m_misses = '0;
  endtask

  // One CPU access: step the model, drive the request, act as memory, then compare.
  task automatic access(input bit wr, input bit rd_too, input logic [31:0] addr,
                        input logic [31:0] wdata, input int n);
    logic [4:0]   idx;
    logic [21:0]  tag;
    logic [2:0]   w;
    int           way, stalls, ntxn, cnt, exp_stall, k;
    bit           exp_hit, exp_wb, in_txn, timeout;
    logic [31:0]  exp_wb_addr, exp_rf_addr, exp_rdata;
    logic [255:0] exp_wb_line;
    logic         txn_wr   [2];
    logic [31:0]  txn_addr [2];
    logic [255:0] txn_data [2];

    idx = addr[9:5];
    tag = addr[31:10];
    w   = addr[4:2];
    way = -1;
    for (int i = 0; i < 2; i++) if (m_valid[i][idx] && m_tag[i][idx] == tag) way = i;
    exp_hit     = (way >= 0);
    exp_wb      = 1'b0;
    exp_stall   = 0;
    exp_wb_addr = 'x;
    exp_wb_line = 'x;
    exp_rf_addr = 'x;
    if (!exp_hit) begin
      way = !m_valid[0][idx] ? 0 : !m_valid[1][idx] ? 1 : int'(m_lru[idx]);
      if (m_valid[way][idx] && m_dirty[way][idx]) begin
        exp_wb      = 1'b1;
        exp_wb_addr = {m_tag[way][idx], idx, 5'b0};
        exp_wb_line = m_line[way][idx];
        model_mem[exp_wb_addr] = exp_wb_line;
      end
      exp_rf_addr        = {tag, idx, 5'b0};
      m_line[way][idx]   = mm_read(exp_rf_addr);
      m_valid[way][idx]  = 1'b1;
      m_dirty[way][idx]  = 1'b0;
      m_tag[way][idx]    = tag;
      m_misses           = m_misses + 1;
      exp_stall          = exp_wb ? 2 * n + 4 : n + 3;
    end else begin
      m_hits = m_hits + 1;
    end
    m_lru[idx] = (way == 0);
    exp_rdata  = m_line[way][idx][w*32 +: 32];
    if (wr) begin
      m_line[way][idx][w*32 +: 32] = wdata;
      m_dirty[way][idx] = 1'b1;
    end

    for (int i = 0; i < 2; i++) begin
      txn_wr[i]   = 'x;
      txn_addr[i] = 'x;
      txn_data[i] = 'x;
    end
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    p1_MemWrite_i = wr;
    p1_MemRead_i  = wr ? rd_too : 1'b1;
    stalls = 0; ntxn = 0; cnt = 0; in_txn = 0; timeout = 0;
    @(negedge clk);
    while (1) begin
      mem_ack_i = 1'b0;
      if (!p1_stall_o) break;
      if (stalls >= 200) begin
        timeout = 1'b1;
        break;
      end
      stalls++;
      if (mem_enable_o) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          cnt    = 0;
          if (ntxn < 2) begin
            txn_wr[ntxn]   = mem_write_o;
            txn_addr[ntxn] = mem_addr_o;
            txn_data[ntxn] = mem_data_o;
          end
          ntxn++;
        end
        cnt++;
        if (cnt == n + 1) begin
          mem_ack_i = 1'b1;
          in_txn    = 1'b0;
          if (mem_write_o) resp_mem[mem_addr_o] = mem_data_o;
          else mem_data_i = rsp_read(mem_addr_o);
        end
      end
      @(negedge clk);
    end

    chk("timeout", timeout, 0);
    chk("stall_cycles", stalls, exp_stall);
    chk("mem_txn_count", ntxn, exp_wb ? 2 : exp_hit ? 0 : 1);
    if (exp_wb) begin
      chk("wb_is_write", txn_wr[0], 1'b1);
      chk("wb_addr", txn_addr[0], exp_wb_addr);
      chk("wb_line", txn_data[0], exp_wb_line);
    end
    if (!exp_hit) begin
      k = exp_wb ? 1 : 0;
      chk("refill_is_read", txn_wr[k], 1'b0);
      chk("refill_addr", txn_addr[k], exp_rf_addr);
    end
    chk("mem_enable_after", mem_enable_o, 1'b0);
    if (!wr) chk("load_data", p1_data_o, exp_rdata);
    @(posedge clk);
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    chk("hit_cnt", hit_cnt_o, m_hits);
    chk("miss_cnt", miss_cnt_o, m_misses);
  endtask

  initial begin
    logic [31:0] a;
    bit          found;

    rst_i = 1'b1;
    mem_data_i = '0; mem_ack_i = 1'b0;
    p1_data_i = '0; p1_addr_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    model_reset();
    #2;
    chk("rst_mem_enable", mem_enable_o, 1'b0);
    chk("rst_mem_write", mem_write_o, 1'b0);
    chk("rst_hit_cnt", hit_cnt_o, 32'd0);
    chk("rst_miss_cnt", miss_cnt_o, 32'd0);
    chk("rst_stall", p1_stall_o, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss, second way fill, hits, store hit, dirty eviction, write miss.
    access(0, 0, 32'h0000_0400, 32'h0, 3);
    access(0, 0, 32'h0000_0800, 32'h0, 2);
    access(0, 0, 32'h0000_0400, 32'h0, 3);
    access(0, 0, 32'h0000_0800, 32'h0, 3);
    access(1, 0, 32'h0000_0404, 32'hDEAD_BEEF, 3);
    access(0, 0, 32'h0000_0404, 32'h0, 3);
    access(0, 0, 32'h0000_0408, 32'h0, 3);
    access(0, 0, 32'h0000_0800, 32'h0, 3);
    access(0, 0, 32'h0000_0C00, 32'h0, 3);
    access(0, 0, 32'h0000_0800, 32'h0, 3);
    access(1, 1, 32'h0000_1008, 32'hCAFE_F00D, 1);
    access(0, 0, 32'h0000_1008, 32'h0, 1);
    access(0, 0, 32'h0000_1400, 32'h0, 0);
    access(0, 0, 32'h0000_1800, 32'h0, 2);

    // Random traffic over a few conflicting tags in a handful of sets.
    for (int i = 0; i < 200; i++) begin
      a = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 4));
    end

    // Reset during a writeback aborts it; everything misses afterwards.
    access(1, 0, 32'h0000_2000, 32'h1111_2222, 1);
    access(1, 0, 32'h0000_2400, 32'h3333_4444, 1);
    p1_addr_i    = 32'h0000_2800;
    p1_MemRead_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (mem_enable_o && mem_write_o) found = 1'b1;
    end
    chk("wb_started", found, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_abort_enable", mem_enable_o, 1'b0);
    chk("rst_abort_write", mem_write_o, 1'b0);
    chk("rst_abort_miss_cnt", miss_cnt_o, 32'd0);
    p1_MemRead_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    access(0, 0, 32'h0000_2000, 32'h0, 2);
    access(0, 0, 32'h0000_2400, 32'h0, 1);
    access(0, 0, 32'h0000_0800, 32'h0, 1);
    access(0, 0, 32'h0000_2000, 32'h0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
